// File: rtl/calc1_pkg.sv
// Shared constants and types for the four-port calc_1 integer calculator.
package calc1_pkg;

  localparam int DATA_W  = 32;
  localparam int CMD_W   = 4;
  localparam int RESP_W  = 2;
  localparam int SHAMT_W = 5;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_RESP = 2'd2
  } port_state_t;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic [DATA_W-1:0] data;
  } alu_res_t;

endpackage

// File: rtl/calc1_if.sv
// Request/response bundle for all four calculator ports (big-endian vectors, bit 0 = MSB).
interface calc1_if;

  logic [0:3]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  logic [0:31] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [0:31] out_data1, out_data2, out_data3, out_data4;
  logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_data1, out_data2, out_data3, out_data4,
    input  out_resp1, out_resp2, out_resp3, out_resp4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_data1, out_data2, out_data3, out_data4,
    output out_resp1, out_resp2, out_resp3, out_resp4
  );

endinterface

// File: rtl/calc1_port.sv
// One calculator port: two-beat request capture, ALU and one-cycle registered response.
module calc1_port
  import calc1_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [CMD_W-1:0]  i_cmd,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic [RESP_W-1:0] o_resp
);

  port_state_t       r_state;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [DATA_W-1:0] r_data;
  logic [RESP_W-1:0] r_resp;
  alu_res_t          w_res;
  logic              w_accept;

  function automatic alu_res_t alu(input logic [CMD_W-1:0]  cmd,
                                   input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
    alu_res_t       res;
    logic [DATA_W:0] sum;
    res = '{resp: RESP_ERR, data: '0};
    sum = {1'b0, a} + {1'b0, b};
    case (cmd)
      CMD_ADD: if (!sum[DATA_W]) res = '{resp: RESP_OK, data: sum[DATA_W-1:0]};
      CMD_SUB: if (b <= a)       res = '{resp: RESP_OK, data: a - b};
      CMD_SHL: res = '{resp: RESP_OK, data: a << b[SHAMT_W-1:0]};
      CMD_SHR: res = '{resp: RESP_OK, data: a >> b[SHAMT_W-1:0]};
      default: res = '{resp: RESP_ERR, data: '0};
    endcase
    return res;
  endfunction

  // A new command is taken from IDLE or on the edge that retires a response.
  assign w_accept = (i_cmd != CMD_NOP) && (r_state == ST_IDLE || r_state == ST_RESP);
  assign w_res    = alu(r_cmd, r_op1, r_op2);

  // Operand capture: pure data, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_cmd <= i_cmd;
      r_op1 <= i_data;
    end
    if (r_state == ST_OP2) begin
      r_op2 <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_resp  <= RESP_NONE;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp <= RESP_NONE;
          r_data <= '0;
          if (w_accept) r_state <= ST_OP2;
        end
        ST_OP2: begin
          r_resp  <= RESP_NONE;
          r_data  <= '0;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_resp  <= w_res.resp;
          r_data  <= w_res.data;
          r_state <= w_accept ? ST_OP2 : ST_IDLE;
        end
        default: begin
          r_resp  <= RESP_NONE;
          r_data  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data = r_data;
  assign o_resp = r_resp;

endmodule

// File: rtl/calc_1.sv
// Four independent calculator ports sharing only clock and reset.
module calc_1
  import calc1_pkg::*;
(
  input  logic       c_clk,
  input  logic [1:7] reset,
  calc1_if.slave     bus
);

  logic w_rst_n;
  logic w_unused_rst;

  // Only reset[1] is meaningful; the remaining bits are don't-care.
  assign w_rst_n      = reset[1];
  assign w_unused_rst = ^reset[2:7];

  calc1_port u_port1 (
    .i_clk   (c_clk),
    .i_rst_n (w_rst_n),
    .i_cmd   (bus.req1_cmd_in),
    .i_data  (bus.req1_data_in),
    .o_data  (bus.out_data1),
    .o_resp  (bus.out_resp1)
  );

  calc1_port u_port2 (
    .i_clk   (c_clk),
    .i_rst_n (w_rst_n),
    .i_cmd   (bus.req2_cmd_in),
    .i_data  (bus.req2_data_in),
    .o_data  (bus.out_data2),
    .o_resp  (bus.out_resp2)
  );

  calc1_port u_port3 (
    .i_clk   (c_clk),
    .i_rst_n (w_rst_n),
    .i_cmd   (bus.req3_cmd_in),
    .i_data  (bus.req3_data_in),
    .o_data  (bus.out_data3),
    .o_resp  (bus.out_resp3)
  );

  calc1_port u_port4 (
    .i_clk   (c_clk),
    .i_rst_n (w_rst_n),
    .i_cmd   (bus.req4_cmd_in),
    .i_data  (bus.req4_data_in),
    .o_data  (bus.out_data4),
    .o_resp  (bus.out_resp4)
  );

endmodule

// File: tb/tb_calc_1.sv
// Self-checking bench for calc_1: directed cases, sweeps, parallel ports, reset abort, random streams.
module tb_calc_1;
  import calc1_pkg::*;

  logic       c_clk = 1'b0;
  logic [1:7] reset;

  always #5 c_clk = ~c_clk;

  calc1_if bus ();

  calc_1 dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  localparam int L = 160;
  logic [3:0]  s_cmd [4][L];
  logic [31:0] s_dat [4][L];
  logic [33:0] s_exp [4][L+3];

  task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d);
    case (p)
      0: begin bus.req1_cmd_in = c; bus.req1_data_in = d; end
      1: begin bus.req2_cmd_in = c; bus.req2_data_in = d; end
      2: begin bus.req3_cmd_in = c; bus.req3_data_in = d; end
      default: begin bus.req4_cmd_in = c; bus.req4_data_in = d; end
    endcase
  endtask

  task automatic idle_all();
    for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'd0);
  endtask

  function automatic logic [33:0] get_out(input int p);
    case (p)
      0: return {bus.out_resp1, bus.out_data1};
      1: return {bus.out_resp2, bus.out_data2};
      2: return {bus.out_resp3, bus.out_data3};
      default: return {bus.out_resp4, bus.out_data4};
    endcase
  endfunction

  // Reference: {resp, data} from plain wide arithmetic.
  function automatic logic [33:0] ref_calc(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b);
    longint unsigned x, y, s;
    int sh;
    x  = a;
    y  = b;
    sh = int'(b % 32);
    case (cmd)
      4'd1: begin
        s = x + y;
        if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, 32'(s)};
      end
      4'd2: begin
        if (y > x) return {2'd2, 32'd0};
        return {2'd1, 32'(x - y)};
      end
      4'd5: return {2'd1, 32'(x << sh)};
      4'd6: return {2'd1, 32'(x >> sh)};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  // Drives one request and samples the outputs before, during and after the response slot.
  task automatic txn(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                     input logic [31:0] op2, output logic [33:0] o_pre,
                     output logic [33:0] o_at, output logic [33:0] o_post);
    @(negedge c_clk); set_port(p, cmd, op1);
    @(negedge c_clk); set_port(p, 4'd0, op2);
    @(negedge c_clk); set_port(p, 4'd0, 32'd0); o_pre = get_out(p);
    @(negedge c_clk); o_at = get_out(p);
    @(negedge c_clk); o_post = get_out(p);
  endtask

  task automatic test_reset();
    reset = 7'b0000000;
    for (int p = 0; p < 4; p++) set_port(p, 4'd1, 32'h1234);
    for (int c = 0; c < 4; c++) begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (get_out(p) !== 34'd0) begin
          n_err++;
          $display("FAIL reset_hold port%0d: got %h want 0", p + 1, get_out(p));
        end
      end
    end
    idle_all();
    @(negedge c_clk); reset = 7'b1111111;
    for (int c = 0; c < 3; c++) begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (get_out(p) !== 34'd0) begin
          n_err++;
          $display("FAIL reset_idle port%0d: got %h want 0", p + 1, get_out(p));
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [3:0]  t_cmd [9] = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd3, 4'd4, 4'd2, 4'd2, 4'd15};
    logic [31:0] t_a   [9] = '{32'h1, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 32'h1, 32'h5, 32'h7, 32'h9};
    logic [31:0] t_b   [9] = '{32'h1FF_FFFF, 32'h1, 32'hF, 32'h0, 32'h1, 32'h1, 32'h5, 32'h3, 32'h1};
    logic [33:0] t_exp [9] = '{{2'd1, 32'h200_0000}, {2'd2, 32'h0}, {2'd2, 32'h0}, {2'd1, 32'h0},
                               {2'd2, 32'h0}, {2'd2, 32'h0}, {2'd1, 32'h0}, {2'd1, 32'h4},
                               {2'd2, 32'h0}};
    logic [33:0] pre, at, post;
    for (int i = 0; i < 9; i++) begin
      txn(0, t_cmd[i], t_a[i], t_b[i], pre, at, post);
      n_cmp += 3;
      if (pre !== 34'd0) begin
        n_err++; $display("FAIL directed%0d_early: got %h want 0", i, pre);
      end
      if (at !== t_exp[i]) begin
        n_err++; $display("FAIL directed%0d_result: got %h want %h", i, at, t_exp[i]);
      end
      if (post !== 34'd0) begin
        n_err++; $display("FAIL directed%0d_width: got %h want 0", i, post);
      end
    end
  endtask

  task automatic test_sweep();
    logic [33:0] pre, at, post, want;
    logic [31:0] x;
    for (int k = 0; k <= 30; k++) begin
      x = 32'h1 << k;
      txn(k % 4, 4'd1, x, 32'd0, pre, at, post);
      n_cmp++;
      if (at !== {2'd1, x}) begin
        n_err++; $display("FAIL sweep_add k=%0d: got %h want %h", k, at, {2'd1, x});
      end
      txn((k + 1) % 4, 4'd5, x, 32'd1, pre, at, post);
      want = {2'd1, x << 1};
      n_cmp++;
      if (at !== want) begin
        n_err++; $display("FAIL sweep_shl k=%0d: got %h want %h", k, at, want);
      end
      txn((k + 2) % 4, 4'd6, 32'h8000_0000, 32'(k), pre, at, post);
      want = {2'd1, 32'h8000_0000 >> k};
      n_cmp++;
      if (at !== want) begin
        n_err++; $display("FAIL sweep_shr k=%0d: got %h want %h", k, at, want);
      end
    end
    txn(0, 4'd6, 32'h8000_0000, 32'd31, pre, at, post);
    n_cmp++;
    if (at !== {2'd1, 32'd1}) begin
      n_err++; $display("FAIL shr31: got %h want %h", at, {2'd1, 32'd1});
    end
    // Only the low five bits of operand2 set the shift amount (0xFFFFFFE4 -> 4).
    txn(1, 4'd5, 32'h1, 32'hFFFF_FFE4, pre, at, post);
    n_cmp++;
    if (at !== {2'd1, 32'h10}) begin
      n_err++; $display("FAIL shamt_mask: got %h want %h", at, {2'd1, 32'h10});
    end
  endtask

  task automatic test_parallel();
    logic [3:0]  c1 [4] = '{4'd1, 4'd2, 4'd5, 4'd6};
    logic [31:0] a1 [4] = '{32'd10, 32'd100, 32'd3, 32'hF0};
    logic [31:0] b1 [4] = '{32'd20, 32'd1, 32'd4, 32'd4};
    logic [3:0]  c2 [4] = '{4'd6, 4'd1, 4'd3, 4'd2};
    logic [31:0] a2 [4] = '{32'hFFFF_0000, 32'hFFFF_FFFF, 32'd7, 32'd1};
    logic [31:0] b2 [4] = '{32'd16, 32'd2, 32'd7, 32'd2};
    logic [33:0] want;
    @(negedge c_clk); for (int p = 0; p < 4; p++) set_port(p, c1[p], a1[p]);
    @(negedge c_clk); for (int p = 0; p < 4; p++) set_port(p, 4'd0, b1[p]);
    @(negedge c_clk); for (int p = 0; p < 4; p++) set_port(p, c2[p], a2[p]);
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      want = ref_calc(c1[p], a1[p], b1[p]);
      n_cmp++;
      if (get_out(p) !== want) begin
        n_err++; $display("FAIL parallel_a port%0d: got %h want %h", p + 1, get_out(p), want);
      end
      set_port(p, 4'd0, b2[p]);
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (get_out(p) !== 34'd0) begin
        n_err++; $display("FAIL parallel_gap port%0d: got %h want 0", p + 1, get_out(p));
      end
      set_port(p, 4'd0, 32'd0);
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      want = ref_calc(c2[p], a2[p], b2[p]);
      n_cmp++;
      if (get_out(p) !== want) begin
        n_err++; $display("FAIL parallel_b port%0d: got %h want %h", p + 1, get_out(p), want);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] pre, at, post;
    @(negedge c_clk); for (int p = 0; p < 4; p++) set_port(p, 4'd1, 32'd5);
    @(negedge c_clk); for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'd6);
    #1 reset = 7'b0000000;
    for (int c = 0; c < 6; c++) begin
      @(negedge c_clk);
      if (c == 0) idle_all();
      if (c == 2) reset = 7'b1111111;
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (get_out(p) !== 34'd0) begin
          n_err++; $display("FAIL reset_abort c=%0d port%0d: got %h want 0", c, p + 1, get_out(p));
        end
      end
    end
    txn(3, 4'd2, 32'd9, 32'd4, pre, at, post);
    n_cmp++;
    if (at !== {2'd1, 32'd5}) begin
      n_err++; $display("FAIL reset_recover: got %h want %h", at, {2'd1, 32'd5});
    end
  endtask

  task automatic test_back_to_back();
    int c, r;
    logic [3:0]  cmd;
    logic [31:0] a, b;
    logic [33:0] got;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < L; i++) begin
        s_cmd[p][i] = 4'd0;
        s_dat[p][i] = $urandom;
      end
      for (int i = 0; i < L + 3; i++) s_exp[p][i] = 34'd0;
      c = int'($urandom_range(0, 2));
      while (c + 1 < L) begin
        r = int'($urandom_range(0, 9));
        a = $urandom;
        b = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
        case (r)
          0, 1, 9: cmd = 4'd1;
          2, 3:    cmd = 4'd2;
          4, 5:    cmd = 4'd5;
          6, 7:    cmd = 4'd6;
          default: begin
            cmd = 4'($urandom_range(7, 17));
            if (cmd == 4'd0) cmd = 4'd3;
            if (cmd == 4'd1) cmd = 4'd4;
          end
        endcase
        if (r == 3) b = a;
        if (r == 9) a = a | 32'hF000_0000;
        s_cmd[p][c]     = cmd;
        s_dat[p][c]     = a;
        s_dat[p][c + 1] = b;
        s_exp[p][c + 2] = ref_calc(cmd, a, b);
        c += 2 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end
    reset = 7'b1000000;
    for (int t = 0; t < L + 3; t++) begin
      @(negedge c_clk);
      if (t >= 1) begin
        for (int p = 0; p < 4; p++) begin
          got = get_out(p);
          n_cmp++;
          if (got !== s_exp[p][t - 1]) begin
            n_err++;
            $display("FAIL stream port%0d edge%0d: got %h want %h", p + 1, t - 1, got, s_exp[p][t - 1]);
          end
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (t < L) set_port(p, s_cmd[p][t], s_dat[p][t]);
        else       set_port(p, 4'd0, 32'd0);
      end
    end
    reset = 7'b1111111;
  endtask

  initial begin
    reset = 7'b0000000;
    idle_all();
    test_reset();
    test_directed();
    test_sweep();
    test_parallel();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge c_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
